// File: rtl/cache_pkg.sv
// Shared FSM encoding and width helpers for the set-associative cache controller.
package cache_pkg;

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_LOOKUP     = 3'd1;
  localparam logic [2:0] S_WRITEBACK  = 3'd2;
  localparam logic [2:0] S_ALLOCATE   = 3'd3;
  localparam logic [2:0] S_FLUSH_SCAN = 3'd4;
  localparam logic [2:0] S_FLUSH_WB   = 3'd5;

  // Field widths never drop below one bit so degenerate parameters still elaborate.
  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/cache_way_array.sv
// One cache way: per-set valid/dirty/tag/line storage with asynchronous read and
// a single write port (line fill, word merge, dirty clear, global invalidate).
module cache_way_array #(
  parameter int DATA_W     = 32,
  parameter int LINE_WORDS = 4,
  parameter int SETS       = 64,
  parameter int TAG_W      = 22,
  parameter int IDX_W      = 6,
  parameter int WSEL_W     = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [IDX_W-1:0]             idx,
  input  logic                         fill_en,
  input  logic [TAG_W-1:0]             fill_tag,
  input  logic [LINE_WORDS*DATA_W-1:0] fill_line,
  input  logic                         word_we,
  input  logic [WSEL_W-1:0]            word_sel,
  input  logic [DATA_W-1:0]            word_data,
  input  logic                         clean_en,
  input  logic                         inv_all,
  output logic                         valid,
  output logic                         dirty,
  output logic [TAG_W-1:0]             tag,
  output logic [LINE_WORDS*DATA_W-1:0] line
);

  logic [SETS-1:0]              valid_q, valid_d;
  logic [SETS-1:0]              dirty_q, dirty_d;
  logic [TAG_W-1:0]             tag_q  [SETS];
  logic [LINE_WORDS*DATA_W-1:0] line_q [SETS];

  always_comb begin
    valid_d = valid_q;
    dirty_d = dirty_q;
    if (inv_all) valid_d = '0;
    if (fill_en) begin
      valid_d[idx] = 1'b1;
      dirty_d[idx] = 1'b0;
    end
    if (word_we)  dirty_d[idx] = 1'b1;
    if (clean_en) dirty_d[idx] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  // Tag and line contents are meaningless until valid is set, so they carry no reset.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_q[idx]  <= fill_tag;
      line_q[idx] <= fill_line;
    end else if (word_we) begin
      line_q[idx][int'(word_sel)*DATA_W +: DATA_W] <= word_data;
    end
  end

  assign valid = valid_q[idx];
  assign dirty = dirty_q[idx];
  assign tag   = tag_q[idx];
  assign line  = line_q[idx];

endmodule

// File: rtl/assoc_cache_ctrl.sv
// N-way set-associative write-back/write-allocate cache controller with per-set
// round-robin replacement and a full flush walk.
module assoc_cache_ctrl
  import cache_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LINE_WORDS = 4,
  parameter int SETS       = 64,
  parameter int WAYS       = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         read,
  input  logic                         write,
  input  logic                         c_flush,
  input  logic [ADDR_W-1:0]            pr_addr,
  input  logic [DATA_W-1:0]            pr_data,
  output logic [DATA_W-1:0]            data_out,
  output logic                         pr_ready,
  output logic                         busy,
  output logic                         flush_done,
  output logic                         mem_read_req,
  output logic                         mem_write_req,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic [LINE_WORDS*DATA_W-1:0] mem_write_data,
  input  logic [LINE_WORDS*DATA_W-1:0] mem_read_data,
  input  logic                         Ready_signal
);

  localparam int LINE_W = LINE_WORDS * DATA_W;
  localparam int BYTE_W = $clog2(DATA_W / 8);
  localparam int WSEL_W = clog2_min1(LINE_WORDS);
  localparam int OFF_W  = BYTE_W + $clog2(LINE_WORDS);
  localparam int IDX_W  = clog2_min1(SETS);
  localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
  localparam int WAY_W  = clog2_min1(WAYS);

  function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] a);
    return a[ADDR_W-1 -: TAG_W];
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_W-1:0] a);
    return a[OFF_W +: IDX_W];
  endfunction

  function automatic logic [WSEL_W-1:0] addr_word(input logic [ADDR_W-1:0] a);
    return a[BYTE_W +: WSEL_W];
  endfunction

  function automatic logic [ADDR_W-1:0] line_addr(input logic [TAG_W-1:0] t,
                                                  input logic [IDX_W-1:0] i);
    return {t, i, {OFF_W{1'b0}}};
  endfunction

  logic [2:0]        state_q, state_d;
  logic [TAG_W-1:0]  req_tag_q, req_tag_d;
  logic [IDX_W-1:0]  req_idx_q, req_idx_d;
  logic [WSEL_W-1:0] req_word_q, req_word_d;
  logic [DATA_W-1:0] req_data_q, req_data_d;
  logic              req_wr_q, req_wr_d;
  logic [WAY_W-1:0]  victim_q, victim_d;
  logic [IDX_W-1:0]  flush_set_q, flush_set_d;
  logic [WAY_W-1:0]  flush_way_q, flush_way_d;
  logic              pr_ready_q, pr_ready_d;
  logic              flush_done_q, flush_done_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              mem_read_req_q, mem_read_req_d;
  logic              mem_write_req_q, mem_write_req_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [LINE_W-1:0] mem_write_data_q, mem_write_data_d;
  logic [WAY_W-1:0]  rr_q [SETS];
  logic [WAY_W-1:0]  rr_d [SETS];

  logic [IDX_W-1:0]  cur_idx;
  logic [WAYS-1:0]   way_valid, way_dirty, fill_en, word_we, clean_en;
  logic              inv_all;
  logic [TAG_W-1:0]  way_tag  [WAYS];
  logic [LINE_W-1:0] way_line [WAYS];
  logic              hit;
  logic [WAY_W-1:0]  hit_way, vict;
  logic [LINE_W-1:0] hit_line;
  logic [DATA_W-1:0] hit_word;
  logic              flush_last;
  logic              unused_byte_bits;

  assign unused_byte_bits = ^pr_addr[BYTE_W-1:0];

  assign cur_idx = (state_q == S_FLUSH_SCAN || state_q == S_FLUSH_WB) ? flush_set_q : req_idx_q;

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    cache_way_array #(
      .DATA_W(DATA_W), .LINE_WORDS(LINE_WORDS), .SETS(SETS),
      .TAG_W(TAG_W), .IDX_W(IDX_W), .WSEL_W(WSEL_W)
    ) u_way (
      .clk(clk), .rst(rst), .idx(cur_idx),
      .fill_en(fill_en[w]), .fill_tag(req_tag_q), .fill_line(mem_read_data),
      .word_we(word_we[w]), .word_sel(req_word_q), .word_data(req_data_q),
      .clean_en(clean_en[w]), .inv_all(inv_all),
      .valid(way_valid[w]), .dirty(way_dirty[w]), .tag(way_tag[w]), .line(way_line[w])
    );
  end

  // Victim is the lowest invalid way; only a full set falls back to the round-robin pointer.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    vict    = rr_q[req_idx_q];
    for (int w = 0; w < WAYS; w++) begin
      if (way_valid[w] && way_tag[w] == req_tag_q) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!way_valid[w]) vict = WAY_W'(w);
    end
    hit_line = way_line[hit_way];
    hit_word = hit_line[int'(req_word_q)*DATA_W +: DATA_W];
  end

  assign flush_last = (flush_set_q == IDX_W'(SETS - 1)) && (flush_way_q == WAY_W'(WAYS - 1));

  always_comb begin
    state_d          = state_q;
    req_tag_d        = req_tag_q;
    req_idx_d        = req_idx_q;
    req_word_d       = req_word_q;
    req_data_d       = req_data_q;
    req_wr_d         = req_wr_q;
    victim_d         = victim_q;
    flush_set_d      = flush_set_q;
    flush_way_d      = flush_way_q;
    pr_ready_d       = 1'b0;
    flush_done_d     = 1'b0;
    data_out_d       = data_out_q;
    mem_read_req_d   = mem_read_req_q;
    mem_write_req_d  = mem_write_req_q;
    mem_addr_d       = mem_addr_q;
    mem_write_data_d = mem_write_data_q;
    rr_d             = rr_q;
    fill_en          = '0;
    word_we          = '0;
    clean_en         = '0;
    inv_all          = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (c_flush) begin
          flush_set_d = '0;
          flush_way_d = '0;
          state_d     = S_FLUSH_SCAN;
        end else if (write || read) begin
          req_tag_d  = addr_tag(pr_addr);
          req_idx_d  = addr_idx(pr_addr);
          req_word_d = addr_word(pr_addr);
          req_data_d = pr_data;
          req_wr_d   = write;
          state_d    = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (hit) begin
          if (req_wr_q) word_we[hit_way] = 1'b1;
          else          data_out_d       = hit_word;
          pr_ready_d = 1'b1;
          state_d    = S_IDLE;
        end else begin
          victim_d = vict;
          if (way_valid[vict])
            rr_d[req_idx_q] = (rr_q[req_idx_q] == WAY_W'(WAYS - 1)) ? '0 : rr_q[req_idx_q] + WAY_W'(1);
          if (way_valid[vict] && way_dirty[vict]) begin
            mem_write_req_d  = 1'b1;
            mem_addr_d       = line_addr(way_tag[vict], req_idx_q);
            mem_write_data_d = way_line[vict];
            state_d          = S_WRITEBACK;
          end else begin
            mem_read_req_d = 1'b1;
            mem_addr_d     = line_addr(req_tag_q, req_idx_q);
            state_d        = S_ALLOCATE;
          end
        end
      end
      S_WRITEBACK: begin
        if (Ready_signal && mem_write_req_q) begin
          mem_write_req_d = 1'b0;
          mem_read_req_d  = 1'b1;
          mem_addr_d      = line_addr(req_tag_q, req_idx_q);
          state_d         = S_ALLOCATE;
        end
      end
      S_ALLOCATE: begin
        if (Ready_signal && mem_read_req_q) begin
          fill_en[victim_q] = 1'b1;
          mem_read_req_d    = 1'b0;
          state_d           = S_LOOKUP;
        end
      end
      S_FLUSH_SCAN: begin
        if (way_valid[flush_way_q] && way_dirty[flush_way_q]) begin
          mem_write_req_d  = 1'b1;
          mem_addr_d       = line_addr(way_tag[flush_way_q], flush_set_q);
          mem_write_data_d = way_line[flush_way_q];
          state_d          = S_FLUSH_WB;
        end else if (flush_last) begin
          inv_all      = 1'b1;
          flush_done_d = 1'b1;
          for (int s = 0; s < SETS; s++) rr_d[s] = '0;
          state_d = S_IDLE;
        end else if (flush_way_q == WAY_W'(WAYS - 1)) begin
          flush_way_d = '0;
          flush_set_d = flush_set_q + IDX_W'(1);
        end else begin
          flush_way_d = flush_way_q + WAY_W'(1);
        end
      end
      // The cleaned entry is rescanned once and then skipped as clean.
      S_FLUSH_WB: begin
        if (Ready_signal && mem_write_req_q) begin
          clean_en[flush_way_q] = 1'b1;
          mem_write_req_d       = 1'b0;
          state_d               = S_FLUSH_SCAN;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= S_IDLE;
      flush_set_q      <= '0;
      flush_way_q      <= '0;
      pr_ready_q       <= 1'b0;
      flush_done_q     <= 1'b0;
      data_out_q       <= '0;
      mem_read_req_q   <= 1'b0;
      mem_write_req_q  <= 1'b0;
      mem_addr_q       <= '0;
      mem_write_data_q <= '0;
      for (int s = 0; s < SETS; s++) rr_q[s] <= '0;
    end else begin
      state_q          <= state_d;
      flush_set_q      <= flush_set_d;
      flush_way_q      <= flush_way_d;
      pr_ready_q       <= pr_ready_d;
      flush_done_q     <= flush_done_d;
      data_out_q       <= data_out_d;
      mem_read_req_q   <= mem_read_req_d;
      mem_write_req_q  <= mem_write_req_d;
      mem_addr_q       <= mem_addr_d;
      mem_write_data_q <= mem_write_data_d;
      rr_q             <= rr_d;
    end
  end

  always_ff @(posedge clk) begin
    req_tag_q  <= req_tag_d;
    req_idx_q  <= req_idx_d;
    req_word_q <= req_word_d;
    req_data_q <= req_data_d;
    req_wr_q   <= req_wr_d;
    victim_q   <= victim_d;
  end

  assign busy           = (state_q != S_IDLE);
  assign pr_ready       = pr_ready_q;
  assign flush_done     = flush_done_q;
  assign data_out       = data_out_q;
  assign mem_read_req   = mem_read_req_q;
  assign mem_write_req  = mem_write_req_q;
  assign mem_addr       = mem_addr_q;
  assign mem_write_data = mem_write_data_q;

endmodule
